// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird game controller.
//   - game_state_e : encoding of the game state as seen on the game_state port
//   - SPACE_CODE / BREAK_CODE : PS2 bytes the key decoder reacts to
//   - Y_START / Y_MAX / Y_WIDTH : vertical screen limits for the bird
package game_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StDead = 2'b10
  } game_state_e;

  localparam logic [7:0] SPACE_CODE = 8'h29;
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  localparam int unsigned Y_START = 240;
  localparam int unsigned Y_MAX   = 464;
  // Enough bits to hold any row from 0 to Y_MAX.
  localparam int unsigned Y_WIDTH = 10;

endpackage

// File: rtl/bird_game_ctrl_if.sv
// Signal bundle between the game controller and its neighbours.
//   Inputs to the controller : ps2_key_pressed, ps2_out (PS2 interface),
//                              collide, pipe_pass (pipe logic)
//   Outputs of the controller: frame_tick, bird_y, velocity, game_state, score
// The slave modport is the controller's view; master is the environment's view.
interface bird_game_ctrl_if;
  import game_pkg::*;

  logic        ps2_key_pressed;
  logic [7:0]  ps2_out;
  logic        collide;
  logic        pipe_pass;

  logic        frame_tick;
  logic [31:0] bird_y;
  logic [7:0]  velocity;
  game_state_e game_state;
  logic [15:0] score;

  modport master (
    output ps2_key_pressed, ps2_out, collide, pipe_pass,
    input  frame_tick, bird_y, velocity, game_state, score
  );

  modport slave (
    input  ps2_key_pressed, ps2_out, collide, pipe_pass,
    output frame_tick, bird_y, velocity, game_state, score
  );

endinterface

// File: rtl/bird_game_ctrl_ps2_flap_decoder.sv
// Turns the PS2 byte stream into a sticky flap request.
//   clock, reset  : processor clock, synchronous active-high reset
//   key_pressed   : high while key_byte holds a freshly received byte
//   key_byte      : last received PS2 byte
//   clear         : consume the pending flap (frame tick)
//   flap_pending  : a space make code arrived since the last clear
module ps2_flap_decoder
  import game_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [7:0] key_byte,
  input  logic       clear,
  output logic       flap_pending
);

  logic key_prev_q;
  logic break_seen_q, break_seen_d;
  logic pending_q, pending_d;
  logic key_rise;

  assign key_rise = key_pressed & ~key_prev_q;

  always_comb begin
    break_seen_d = break_seen_q;
    pending_d    = pending_q & ~clear;
    if (key_rise) begin
      if (key_byte == BREAK_CODE) begin
        break_seen_d = 1'b1;
      end else begin
        break_seen_d = 1'b0;
        // A set in the same cycle as a clear survives into the next frame.
        if (key_byte == SPACE_CODE && !break_seen_q) begin
          pending_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_prev_q   <= 1'b0;
      break_seen_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      key_prev_q   <= key_pressed;
      break_seen_q <= break_seen_d;
      pending_q    <= pending_d;
    end
  end

  assign flap_pending = pending_q;

endmodule

// File: rtl/bird_game_ctrl.sv
// Per-frame sequencer for the flappy-bird game: frame timing, bird physics,
// game state and score.
//   clock, reset : processor clock, synchronous active-high reset
//   bus (slave)  : ps2_key_pressed/ps2_out in from the PS2 interface,
//                  collide/pipe_pass in from the pipe logic,
//                  frame_tick, bird_y, velocity, game_state, score out
module bird_game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FRAME_DIV   = 166667,
  parameter int          GRAVITY     = 1,
  parameter int          FLAP_VEL    = -8,
  parameter int          V_MAX       = 10,
  parameter int unsigned DEAD_FRAMES = 60
) (
  input logic              clock,
  input logic              reset,
  bird_game_ctrl_if.slave  bus
);

  localparam int unsigned CntW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned DeadW = $clog2(DEAD_FRAMES + 1);

  localparam logic [CntW-1:0]    CntLast  = CntW'(FRAME_DIV - 1);
  localparam logic [DeadW-1:0]   DeadLast = DeadW'(DEAD_FRAMES);
  localparam logic signed [7:0]  FlapV    = 8'(FLAP_VEL);
  localparam logic signed [7:0]  GravV    = 8'(GRAVITY);
  localparam logic signed [7:0]  VMaxV    = 8'(V_MAX);
  localparam logic signed [11:0] YMaxS    = 12'(Y_MAX);
  localparam logic [Y_WIDTH-1:0] YStartV  = Y_WIDTH'(Y_START);
  localparam logic [Y_WIDTH-1:0] YMaxV    = Y_WIDTH'(Y_MAX);

  // Frame timing
  logic [CntW-1:0] cnt_q;
  logic            tick_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CntLast);
      cnt_q  <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  // Key decode; every frame tick consumes the pending flap, whatever the state.
  logic flap_pending;

  ps2_flap_decoder u_flap_decoder (
    .clock        (clock),
    .reset        (reset),
    .key_pressed  (bus.ps2_key_pressed),
    .key_byte     (bus.ps2_out),
    .clear        (tick_q),
    .flap_pending (flap_pending)
  );

  // Game state and datapath registers
  game_state_e         state_q, state_d;
  logic [Y_WIDTH-1:0]  y_q, y_d;
  logic signed [7:0]   vel_q, vel_d;
  logic [DeadW-1:0]    dead_q, dead_d;
  logic [15:0]         score_q, score_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      y_q     <= YStartV;
      vel_q   <= '0;
      dead_q  <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      dead_q  <= dead_d;
      score_q <= score_d;
    end
  end

  // Candidate physics step; in IDLE y_q sits at Y_START so the same sum
  // yields the first PLAY position.
  logic signed [7:0]  v_grav;
  logic signed [7:0]  v_next;
  logic signed [11:0] y_sum;

  always_comb begin
    v_grav = vel_q + GravV;
    if (v_grav > VMaxV) begin
      v_grav = VMaxV;
    end
    v_next = flap_pending ? FlapV : v_grav;
    y_sum  = $signed({2'b00, y_q}) + $signed({{4{v_next[7]}}, v_next});
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    dead_d  = dead_q;
    score_d = score_q;

    // Score runs on the pipe pulse, not on the frame tick.
    if (state_q == StPlay && bus.pipe_pass && score_q != 16'hFFFF) begin
      score_d = score_q + 16'd1;
    end

    if (tick_q) begin
      unique case (state_q)
        StIdle: begin
          if (flap_pending) begin
            state_d = StPlay;
            vel_d   = FlapV;
            y_d     = y_sum[Y_WIDTH-1:0];
          end
        end
        StPlay: begin
          if (y_sum <= 12'sd0) begin
            // Hitting the ceiling stops the bird but is not fatal.
            y_d   = '0;
            vel_d = '0;
          end else if (y_sum >= YMaxS) begin
            y_d     = YMaxV;
            state_d = StDead;
          end else begin
            y_d   = y_sum[Y_WIDTH-1:0];
            vel_d = v_next;
          end
          // Collision overrides any flap; the position update above stands.
          if (bus.collide) begin
            state_d = StDead;
          end
          if (state_d == StDead) begin
            vel_d  = '0;
            dead_d = '0;
          end
        end
        StDead: begin
          if (dead_q == DeadLast) begin
            if (flap_pending) begin
              state_d = StIdle;
              y_d     = YStartV;
              score_d = '0;
            end
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          y_d     = YStartV;
          vel_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.frame_tick = tick_q;
    bus.bird_y     = {{(32 - Y_WIDTH){1'b0}}, y_q};
    bus.velocity   = vel_q;
    bus.game_state = state_q;
    bus.score      = score_q;
  end

endmodule

// File: tb/tb_bird_game_ctrl.sv
// Self-checking bench for bird_game_ctrl: directed game scenarios followed by
// randomized key, pipe, collide and reset traffic, all compared each cycle
// against a frame-level behavioural model of the game rules.
module tb_bird_game_ctrl;
  import game_pkg::*;

  localparam int FD = 10;
  localparam int DF = 60;

  logic clock = 1'b0;
  logic reset;

  bird_game_ctrl_if bus ();

  bird_game_ctrl #(
    .FRAME_DIV   (FD),
    .DEAD_FRAMES (DF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: plain integers, states as 0 idle / 1 play / 2 dead.
  int m_cnt, m_tick, m_state, m_y, m_v, m_score, m_pend, m_brk, m_dead, m_prev;

  task automatic check_eq(input string tag, input logic signed [31:0] act,
                          input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Apply the game rules for one clock edge using the inputs present at it.
  task automatic model_step();
    int  v_n, y_n, new_score;
    bit  rise, tick_now, die;
    if (reset) begin
      m_cnt = 0; m_tick = 0; m_state = 0; m_y = 240; m_v = 0; m_score = 0;
      m_pend = 0; m_brk = 0; m_dead = 0; m_prev = 0;
      return;
    end
    tick_now  = (m_tick != 0);
    rise      = bus.ps2_key_pressed && (m_prev == 0);
    new_score = m_score;
    if (m_state == 1 && bus.pipe_pass && m_score < 65535) new_score = m_score + 1;
    if (tick_now) begin
      if (m_state == 0) begin
        if (m_pend != 0) begin
          m_state = 1; m_v = -8; m_y = 240 - 8;
        end
      end else if (m_state == 1) begin
        die = 0;
        v_n = (m_pend != 0) ? -8 : ((m_v + 1 > 10) ? 10 : m_v + 1);
        y_n = m_y + v_n;
        if (y_n <= 0) begin
          m_y = 0; m_v = 0;
        end else if (y_n >= 464) begin
          m_y = 464; die = 1;
        end else begin
          m_y = y_n; m_v = v_n;
        end
        if (bus.collide) die = 1;
        if (die) begin
          m_state = 2; m_v = 0; m_dead = 0;
        end
      end else begin
        if (m_dead == DF) begin
          if (m_pend != 0) begin
            m_state = 0; m_y = 240; m_v = 0; new_score = 0;
          end
        end else begin
          m_dead++;
        end
      end
      m_pend = 0;
    end
    if (rise) begin
      if (bus.ps2_out == 8'hF0) m_brk = 1;
      else begin
        if (bus.ps2_out == 8'h29 && m_brk == 0) m_pend = 1;
        m_brk = 0;
      end
    end
    m_score = new_score;
    m_tick  = (m_cnt == FD - 1) ? 1 : 0;
    m_cnt   = (m_cnt == FD - 1) ? 0 : m_cnt + 1;
    m_prev  = bus.ps2_key_pressed ? 1 : 0;
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_eq("frame_tick", {31'b0, bus.frame_tick}, m_tick);
    check_eq("bird_y", bus.bird_y, m_y);
    check_eq("velocity", $signed(bus.velocity), m_v);
    check_eq("game_state", {30'b0, bus.game_state}, m_state);
    check_eq("score", {16'b0, bus.score}, m_score);
  endtask

  task automatic send_key(input logic [7:0] b);
    bus.ps2_out = b;
    bus.ps2_key_pressed = 1'b1;
    cyc();
    bus.ps2_key_pressed = 1'b0;
    cyc();
  endtask

  task automatic pulse_pipe();
    bus.pipe_pass = 1'b1;
    cyc();
    bus.pipe_pass = 1'b0;
    cyc();
  endtask

  // Run through the next frame tick and the cycle where its update shows.
  task automatic next_frame();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.frame_tick && n < 2 * FD);
    if (!bus.frame_tick) check_eq("tick_timeout", 0, 1);
    cyc();
  endtask

  initial begin
    int n, r, kp;
    reset = 1'b1;
    bus.ps2_key_pressed = 1'b0;
    bus.ps2_out = 8'h00;
    bus.collide = 1'b0;
    bus.pipe_pass = 1'b0;

    // Reset state
    repeat (3) cyc();
    check_eq("rst_bird_y", bus.bird_y, 240);
    check_eq("rst_state", {30'b0, bus.game_state}, 0);
    check_eq("rst_score", {16'b0, bus.score}, 0);
    check_eq("rst_tick", {31'b0, bus.frame_tick}, 0);
    reset = 1'b0;

    // Tick period
    n = 0;
    while (!bus.frame_tick && n < 3 * FD) begin cyc(); n++; end
    n = 0;
    do begin cyc(); n++; end while (!bus.frame_tick && n < 3 * FD);
    check_eq("tick_period", n, FD);

    // Start from IDLE and follow the first frames
    send_key(8'h29);
    next_frame();
    check_eq("start_state", {30'b0, bus.game_state}, 1);
    check_eq("start_vel", $signed(bus.velocity), -8);
    check_eq("start_y", bus.bird_y, 232);
    next_frame(); check_eq("y_f2", bus.bird_y, 225);
    next_frame(); check_eq("y_f3", bus.bird_y, 219);
    next_frame(); check_eq("y_f4", bus.bird_y, 214);
    repeat (16) next_frame();
    check_eq("vel_cap", $signed(bus.velocity), 10);
    next_frame();
    check_eq("vel_cap_hold", $signed(bus.velocity), 10);
    check_eq("y_capped", bus.bird_y, 279);

    // Released key must not flap again
    send_key(8'h29);
    next_frame();
    check_eq("flap_vel", $signed(bus.velocity), -8);
    check_eq("flap_y", bus.bird_y, 271);
    send_key(8'hF0);
    send_key(8'h29);
    next_frame();
    check_eq("break_no_flap", $signed(bus.velocity), -7);

    // Score, then collide together with a flap
    repeat (3) pulse_pipe();
    check_eq("score3", {16'b0, bus.score}, 3);
    next_frame();
    bus.collide = 1'b1;
    send_key(8'h29);
    next_frame();
    bus.collide = 1'b0;
    check_eq("collide_dead", {30'b0, bus.game_state}, 2);
    check_eq("collide_y", bus.bird_y, 250);
    pulse_pipe();
    check_eq("dead_score_frozen", {16'b0, bus.score}, 3);

    // Restart boundary: a flap consumed on the last dead frame is dropped
    repeat (DF - 1) next_frame();
    send_key(8'h29);
    next_frame();
    check_eq("dead_boundary", {30'b0, bus.game_state}, 2);
    send_key(8'h29);
    next_frame();
    check_eq("restart_state", {30'b0, bus.game_state}, 0);
    check_eq("restart_y", bus.bird_y, 240);
    check_eq("restart_score", {16'b0, bus.score}, 0);
    pulse_pipe();
    check_eq("idle_pipe", {16'b0, bus.score}, 0);

    // Fall to the floor
    send_key(8'h29);
    next_frame();
    n = 0;
    while (bus.game_state != StDead && n < 60) begin next_frame(); n++; end
    check_eq("floor_state", {30'b0, bus.game_state}, 2);
    check_eq("floor_y", bus.bird_y, 464);
    check_eq("floor_vel", $signed(bus.velocity), 0);
    repeat (30) next_frame();
    send_key(8'h29);
    repeat (30) next_frame();
    check_eq("early_flap_ignored", {30'b0, bus.game_state}, 2);
    send_key(8'h29);
    next_frame();
    check_eq("floor_restart", {30'b0, bus.game_state}, 0);

    // Reset mid-play with a pending flap
    send_key(8'h29);
    next_frame();
    next_frame();
    send_key(8'h29);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_eq("midrst_y", bus.bird_y, 240);
    check_eq("midrst_state", {30'b0, bus.game_state}, 0);
    check_eq("midrst_vel", $signed(bus.velocity), 0);
    next_frame();
    check_eq("midrst_no_flap", {30'b0, bus.game_state}, 0);

    // Randomized traffic
    kp = 5;
    for (int i = 0; i < 8000; i++) begin
      if (i % 500 == 0) kp = $urandom_range(2, 40);
      reset = ($urandom_range(0, 1499) == 0);
      if (bus.ps2_key_pressed || reset) begin
        bus.ps2_key_pressed = 1'b0;
      end else if ($urandom_range(0, kp) == 0) begin
        bus.ps2_key_pressed = 1'b1;
        r = $urandom_range(0, 7);
        bus.ps2_out = (r < 4) ? 8'h29 : (r < 6) ? 8'hF0 : 8'($urandom_range(0, 255));
      end
      bus.pipe_pass = ($urandom_range(0, 11) == 0);
      if (!bus.collide && $urandom_range(0, 799) == 0) bus.collide = 1'b1;
      else if (bus.collide && $urandom_range(0, 19) == 0) bus.collide = 1'b0;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
